// File: rtl/i2c_reg_pkg.sv
// i2c_reg_pkg: shared types and constants for the I2C register bridge.
//   state_e      - protocol FSM states
//   NUM_REGS_DEF - default register count
//   AW_DEF       - default register address width
//   ACK / NACK   - SDA level of the acknowledge bit
package i2c_reg_pkg;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT
  } state_e;

  localparam int   NUM_REGS_DEF = 37;
  localparam int   AW_DEF       = 6;
  localparam logic ACK          = 1'b0;
  localparam logic NACK         = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: synchronizes raw SCL/SDA and detects bus events.
// Optional macro: I2C_GLITCH_FILTER_EN adds a 3-sample majority filter
// after the 2-FF synchronizers (rejects pulses shorter than 2 clks).
// Ports:
//   clk, rst          - system clock, async active-high reset
//   scl_in, sda_in    - raw pad levels
//   scl_rise/scl_fall - one-clk pulses on synchronized SCL edges
//   start_det         - SDA fall while SCL high
//   stop_det          - SDA rise while SCL high
//   sda_s             - synchronized (filtered) SDA level
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_f, sda_f;
  logic       scl_prev_q, sda_prev_q;

  // Idle bus is high; reset to 1 so no edge is seen after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_in};
      sda_sync_q <= {sda_sync_q[0], sda_in};
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic [2:0] scl_hist_q, sda_hist_q;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_hist_q <= 3'b111;
      sda_hist_q <= 3'b111;
    end else begin
      scl_hist_q <= {scl_hist_q[1:0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[1:0], sda_sync_q[1]};
    end
  end

  assign scl_f = maj3(scl_hist_q);
  assign sda_f = maj3(sda_hist_q);
`else
  assign scl_f = scl_sync_q[1];
  assign sda_f = sda_sync_q[1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_f;
      sda_prev_q <= sda_f;
    end
  end

  assign scl_rise  = scl_f & ~scl_prev_q;
  assign scl_fall  = ~scl_f & scl_prev_q;
  assign start_det = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
  assign stop_det  = scl_f & scl_prev_q & ~sda_prev_q & sda_f;
  assign sda_s     = sda_f;

endmodule

// File: rtl/i2c_reg_bridge.sv
// i2c_reg_bridge: I2C slave that turns bus transfers into register-file
// write/read strobes. Byte after a write address sets the register
// pointer; following bytes are written; reads stream from the pointer.
// Optional macro: I2C_GLITCH_FILTER_EN (see i2c_line_sync).
// Ports:
//   clk, rst            - system clock, async active-high reset
//   scl_in, sda_in      - raw pad levels
//   sda_oe              - 1 pulls SDA low
//   reg_addr/reg_wdata  - register file address / write data
//   reg_write/reg_read  - strobes, REG_PULSE clks wide
//   reg_rdata           - register file read data
//   busy                - FSM not in IDLE
//
// state    | meaning
// IDLE     | bus free, waiting for START
// ADDR     | shifting in device address + R/W
// ADDR_ACK | driving ACK for address match
// PTR      | shifting in register pointer
// PTR_ACK  | driving ACK for valid pointer
// WR_DATA  | shifting in a write data byte
// WR_ACK   | driving ACK after a write was issued
// RD_DATA  | shifting out a fetched byte
// RD_ACK   | sampling master ACK/NACK
// WAIT     | released, waiting for STOP/START
module i2c_reg_bridge
  import i2c_reg_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = 7'h42,
  parameter int         NUM_REGS  = NUM_REGS_DEF,
  parameter int         AW        = AW_DEF,
  parameter int         REG_PULSE = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl_in,
  input  logic          sda_in,
  output logic          sda_oe,
  output logic [AW-1:0] reg_addr,
  output logic [7:0]    reg_wdata,
  output logic          reg_write,
  output logic          reg_read,
  input  logic [7:0]    reg_rdata,
  output logic          busy
);

  localparam logic [7:0]    NUM_REGS_B = 8'(NUM_REGS);
  localparam logic [AW-1:0] LAST_PTR   = AW'(NUM_REGS - 1);
  localparam logic [3:0]    PULSE_LD   = 4'(REG_PULSE);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_line_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    tx_q, tx_d;
  logic [AW-1:0] ptr_q, ptr_d, ptr_inc;
  logic          sda_oe_q, sda_oe_d;
  logic          rw_q, rw_d;
  logic          mack_q, mack_d;
  logic          wr_go, rd_go;
  logic [AW-1:0] go_addr;

  logic [AW-1:0] reg_addr_q;
  logic [7:0]    reg_wdata_q, rd_q;
  logic          reg_write_q, reg_read_q, cap_q;
  logic [3:0]    pulse_q;

  assign ptr_inc = (ptr_q == LAST_PTR) ? '0 : ptr_q + AW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sh_q     <= '0;
      tx_q     <= '0;
      ptr_q    <= '0;
      sda_oe_q <= 1'b0;
      rw_q     <= 1'b0;
      mack_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      tx_q     <= tx_d;
      ptr_q    <= ptr_d;
      sda_oe_q <= sda_oe_d;
      rw_q     <= rw_d;
      mack_q   <= mack_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    tx_d     = tx_q;
    ptr_d    = ptr_q;
    sda_oe_d = sda_oe_q;
    rw_d     = rw_q;
    mack_d   = mack_q;
    wr_go    = 1'b0;
    rd_go    = 1'b0;
    go_addr  = ptr_q;

    if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
    end else if (start_det) begin
      state_d  = ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
    end else begin
      if (scl_rise && cnt_q != 4'd8 &&
          (state_q == ADDR || state_q == PTR || state_q == WR_DATA || state_q == RD_DATA)) begin
        sh_d  = {sh_q[6:0], sda_s};
        cnt_d = cnt_q + 4'd1;
      end
      case (state_q)
        ADDR: if (scl_fall && cnt_q == 4'd8) begin
          if (sh_q[7:1] == DEV_ADDR) begin
            state_d  = ADDR_ACK;
            sda_oe_d = 1'b1;
            rw_d     = sh_q[0];
            rd_go    = sh_q[0];
          end else begin
            state_d = WAIT;
          end
        end
        ADDR_ACK: if (scl_fall) begin
          cnt_d = '0;
          if (rw_q) begin
            state_d  = RD_DATA;
            sda_oe_d = ~rd_q[7];
            tx_d     = {rd_q[6:0], 1'b0};
          end else begin
            state_d  = PTR;
            sda_oe_d = 1'b0;
          end
        end
        PTR: if (scl_fall && cnt_q == 4'd8) begin
          if (sh_q < NUM_REGS_B) begin
            ptr_d    = sh_q[AW-1:0];
            state_d  = PTR_ACK;
            sda_oe_d = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
        PTR_ACK, WR_ACK: if (scl_fall) begin
          state_d  = WR_DATA;
          cnt_d    = '0;
          sda_oe_d = 1'b0;
        end
        WR_DATA: if (scl_fall && cnt_q == 4'd8) begin
          wr_go    = 1'b1;
          ptr_d    = ptr_inc;
          state_d  = WR_ACK;
          sda_oe_d = 1'b1;
        end
        RD_DATA: if (scl_fall) begin
          if (cnt_q == 4'd8) begin
            state_d  = RD_ACK;
            sda_oe_d = 1'b0;
          end else begin
            sda_oe_d = ~tx_q[7];
            tx_d     = {tx_q[6:0], 1'b0};
          end
        end
        RD_ACK: begin
          // Fetch on the ACK rise so data is ready by the next SCL fall.
          if (scl_rise) begin
            mack_d = (sda_s == ACK);
            if (sda_s == ACK) begin
              ptr_d   = ptr_inc;
              rd_go   = 1'b1;
              go_addr = ptr_inc;
            end
          end
          if (scl_fall) begin
            if (mack_q) begin
              state_d  = RD_DATA;
              cnt_d    = '0;
              sda_oe_d = ~rd_q[7];
              tx_d     = {rd_q[6:0], 1'b0};
            end else begin
              state_d = WAIT;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Strobe generator: pulse_q counts down the remaining high cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_write_q <= 1'b0;
      reg_read_q  <= 1'b0;
      pulse_q     <= '0;
      cap_q       <= 1'b0;
      rd_q        <= '0;
    end else if (wr_go) begin
      reg_write_q <= 1'b1;
      reg_addr_q  <= go_addr;
      reg_wdata_q <= sh_q;
      pulse_q     <= PULSE_LD;
    end else if (rd_go) begin
      reg_read_q <= 1'b1;
      reg_addr_q <= go_addr;
      pulse_q    <= PULSE_LD;
    end else if (reg_write_q || reg_read_q) begin
      pulse_q <= pulse_q - 4'd1;
      if (pulse_q == 4'd1) begin
        reg_write_q <= 1'b0;
        reg_read_q  <= 1'b0;
        cap_q       <= reg_read_q;
      end
    end else begin
      cap_q <= 1'b0;
      if (cap_q) rd_q <= reg_rdata;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_write = reg_write_q;
  assign reg_read  = reg_read_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_reg_bridge.sv
// tb_i2c_reg_bridge: bus-level I2C master driving i2c_reg_bridge, with a
// behavioural register file and expected strobe lists from pointer arithmetic.
module tb_i2c_reg_bridge;
  localparam int NR = 37;
  localparam int Q  = 5;

  logic       clk = 1'b0, rst = 1'b1, scl_drv = 1'b1, sda_m = 1'b1;
  logic       sda_in, sda_oe, reg_write, reg_read, busy;
  logic [5:0] reg_addr;
  logic [7:0] reg_wdata, reg_rdata;
  logic [7:0] regs [0:NR-1];

  assign sda_in    = sda_m & ~sda_oe;
  assign reg_rdata = (reg_addr < 6'(NR)) ? regs[reg_addr] : 8'h00;

  always #5 clk = ~clk;

  i2c_reg_bridge dut (
    .clk(clk), .rst(rst), .scl_in(scl_drv), .sda_in(sda_in), .sda_oe(sda_oe),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_write(reg_write),
    .reg_read(reg_read), .reg_rdata(reg_rdata), .busy(busy)
  );

  int total = 0, passed = 0;
  logic [23:0] wr_log[$];
  logic [15:0] rd_log[$];
  int wr_idx = 0, rd_idx = 0;
  logic [7:0] wq[$];
  bit overlap = 0;

  logic       wp = 0, rp = 0;
  logic [7:0] wa, wd, wl, ra, rl;
  always @(negedge clk) begin
    if (reg_write && reg_read) overlap = 1;
    if (reg_write) begin
      if (!wp) begin wa = {2'b00, reg_addr}; wd = reg_wdata; wl = 0; end
      wl++;
    end else if (wp) wr_log.push_back({wl, wa, wd});
    if (reg_read) begin
      if (!rp) begin ra = {2'b00, reg_addr}; rl = 0; end
      rl++;
    end else if (rp) rd_log.push_back({rl, ra});
    wp = reg_write;
    rp = reg_read;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic hclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clk_bit(input logic b, output logic s);
    sda_m = b;      hclk(Q);
    scl_drv = 1'b1; hclk(Q);
    s = sda_in;     hclk(Q);
    scl_drv = 1'b0; hclk(Q);
  endtask

  task automatic start_cond();
    sda_m = 1'b1; hclk(Q); scl_drv = 1'b1; hclk(Q);
    sda_m = 1'b0; hclk(Q); scl_drv = 1'b0; hclk(Q);
  endtask

  task automatic stop_cond();
    sda_m = 1'b0; hclk(Q); scl_drv = 1'b1; hclk(Q);
    sda_m = 1'b1; hclk(2 * Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin clk_bit(1'b1, s); b[i] = s; end
    clk_bit(mack, s);
  endtask

  task automatic chk_no_strobes(input string tag);
    chk({tag, "_wr"}, wr_log.size(), wr_idx);
    chk({tag, "_rd"}, rd_log.size(), rd_idx);
  endtask

  // Writes wq starting at pointer p; expects address (p+i) mod NR per byte.
  task automatic do_write(input int p);
    logic a;
    logic [23:0] e;
    start_cond();
    send_byte(8'h84, a);   chk("w_addr_ack", a, 0);
    send_byte(8'(p), a);   chk("w_ptr_ack", a, 0);
    foreach (wq[i]) begin send_byte(wq[i], a); chk("w_data_ack", a, 0); end
    stop_cond(); hclk(4);
    for (int i = 0; i < wq.size(); i++) begin
      if (wr_idx < wr_log.size()) begin
        e = wr_log[wr_idx]; wr_idx++;
        chk("w_strobe_addr", e[15:8], (p + i) % NR);
        chk("w_strobe_data", e[7:0], wq[i]);
        chk("w_strobe_width", e[23:16], 2);
      end else chk("w_strobe_count", wr_log.size(), wr_idx + 1);
    end
    chk("w_extra", wr_log.size(), wr_idx);
    chk("w_busy_after_stop", busy, 0);
  endtask

  task automatic do_read(input int p, input int n);
    logic a;
    logic [7:0] b;
    logic [15:0] e;
    start_cond();
    send_byte(8'h84, a); chk("r_waddr_ack", a, 0);
    send_byte(8'(p), a); chk("r_ptr_ack", a, 0);
    start_cond();
    send_byte(8'h85, a); chk("r_raddr_ack", a, 0);
    for (int i = 0; i < n; i++) begin
      recv_byte((i == n - 1) ? 1'b1 : 1'b0, b);
      chk("r_data", b, regs[(p + i) % NR]);
    end
    stop_cond(); hclk(4);
    for (int i = 0; i < n; i++) begin
      if (rd_idx < rd_log.size()) begin
        e = rd_log[rd_idx]; rd_idx++;
        chk("r_strobe_addr", e[7:0], (p + i) % NR);
        chk("r_strobe_width", e[15:8], 2);
      end else chk("r_strobe_count", rd_log.size(), rd_idx + 1);
    end
    chk("r_extra", rd_log.size(), rd_idx);
    chk("w_during_read", wr_log.size(), wr_idx);
  endtask

  initial begin
    logic a;
    for (int i = 0; i < NR; i++) regs[i] = 8'($urandom);
    regs[16] = 8'h3C;
    regs[17] = 8'hC3;
    hclk(3);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_reg_write", reg_write, 0);
    chk("rst_reg_read", reg_read, 0);
    chk("rst_reg_addr", reg_addr, 0);
    chk("rst_reg_wdata", reg_wdata, 0);
    rst = 1'b0;
    hclk(5);

    wq = '{8'h55, 8'hAA};
    do_write(6);

    do_read(16, 2);

    wq = '{8'h01, 8'h02};
    do_write(36);

    start_cond();
    send_byte(8'h20, a); chk("bad_dev_nack", a, 1);
    send_byte(8'h5A, a); chk("bad_dev_data_nack", a, 1);
    chk("bad_dev_busy", busy, 1);
    stop_cond(); hclk(4);
    chk("bad_dev_idle", busy, 0);
    chk_no_strobes("bad_dev");

    start_cond();
    send_byte(8'h84, a); chk("bad_ptr_addr_ack", a, 0);
    send_byte(8'h30, a); chk("bad_ptr_nack", a, 1);
    send_byte(8'h77, a); chk("bad_ptr_data_nack", a, 1);
    chk("bad_ptr_busy", busy, 1);
    stop_cond(); hclk(4);
    chk("bad_ptr_idle", busy, 0);
    chk_no_strobes("bad_ptr");
    wq = '{8'h9E};
    do_write(0);

`ifdef I2C_GLITCH_FILTER_EN
    sda_m = 1'b0; hclk(1); sda_m = 1'b1; hclk(10);
    chk("glitch_no_start", busy, 0);
`endif

    start_cond();
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] ab;
      ab = 8'h84;
      clk_bit(ab[i], a);
    end
    sda_m = 1'b1; hclk(Q);
    chk("rst_mid_ack_driven", sda_oe, 1);
    rst = 1'b1; #1;
    chk("rst_mid_sda_release", sda_oe, 0);
    chk("rst_mid_idle", busy, 0);
    hclk(2); rst = 1'b0;
    scl_drv = 1'b1; hclk(4 * Q);
    chk_no_strobes("rst_mid");

    for (int k = 0; k < 6; k++) begin
      int p, n;
      p = $urandom_range(0, NR - 1);
      n = $urandom_range(1, 4);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
      do_write(p);
      p = $urandom_range(0, NR - 1);
      do_read(p, $urandom_range(1, 3));
    end

    chk("strobe_overlap", overlap, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/i2c_reg_bridge.md
Name: i2c_reg_bridge

Overview:
I2C slave protocol engine that acts as initiator on the register-file access interface (address, write data, write strobe, read strobe, read data).
- Decodes START/STOP, device address, a register-pointer byte and data bytes from the synchronized SCL/SDA lines.
- Issues write and read strobes to the register file, and serializes read data back onto SDA.
- Sits between the pad-level open-drain I2C lines and the register file.

Parameters:
DEV_ADDR, 7'h42, 7-bit I2C device address matched after START
NUM_REGS, 37, number of addressable registers; pointer range 0..NUM_REGS-1
AW, 6, register address width
REG_PULSE, 2, clk cycles each reg_write/reg_read strobe is held high (min 2)

Ports:
clk  in  1  system clock; must be at least 16x SCL frequency
rst  in  1  asynchronous, active-high reset
scl_in  in  1  raw SCL from pad
sda_in  in  1  raw SDA from pad
sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release
reg_addr  out  AW  register address to register file
reg_wdata  out  8  write data to register file
reg_write  out  1  write strobe
reg_read  out  1  read strobe
reg_rdata  in  8  read data from register file
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset is asynchronous and active-high. Reset values: sda_oe=0, reg_write=0, reg_read=0, reg_addr=0, reg_wdata=0, busy=0, pointer=0, FSM=IDLE. Asserting rst mid-transfer releases SDA immediately.
- SCL and SDA pass through 2-FF synchronizers. Edges are detected on the synchronized values.
  - START = SDA fall while SCL high.
  - STOP = SDA rise while SCL high.
  - Bits are sampled on SCL rise. SDA is changed only on the clk after SCL fall.
- STOP in any state -> IDLE. START in any state -> ADDR (repeated START allowed). Bit counter clears on START.
- FSM states and transitions:
  - IDLE: waits for START.
  - ADDR: shifts in 8 bits (MSB first). On match with DEV_ADDR -> ADDR_ACK, drive ACK; with R/W=1, also launch a read fetch. No match -> WAIT, SDA released, no strobes.
  - PTR: receives the pointer byte. Value < NUM_REGS -> latch pointer, ACK, -> WR_DATA. Value >= NUM_REGS -> NACK, -> WAIT.
  - WR_DATA: after 8th bit, issue a write: reg_addr=pointer, reg_wdata=byte, reg_write high REG_PULSE cycles. Then ACK, increment pointer, stay in WR_DATA.
  - RD_DATA: shift out the fetched byte MSB first, one bit per SCL low phase. Master ACK -> increment pointer, launch fetch, next byte. Master NACK -> WAIT.
  - WAIT: SDA released; leaves only on STOP/START.
- Read fetch: reg_addr=pointer, reg_read high REG_PULSE cycles, reg_rdata captured on the first clk after reg_read falls. Fetch latency is REG_PULSE+1 clks and completes before the next SCL fall.
- reg_write and reg_read are never high together.
- At least one idle clk separates consecutive strobes.
- Pointer wrap: after access at NUM_REGS-1 the pointer becomes 0.
- Writes to read-only registers are issued and ACKed anyway; the register file ignores them.
- ACK drive lasts from the SCL fall after bit 8 to the following SCL fall.

Optional Feature:
I2C_GLITCH_FILTER_EN
- Defined: synchronized SCL/SDA pass through a 3-sample majority filter before edge detection. Pulses shorter than 2 clks are rejected; detection latency +2 clks.
- Undefined: edge detection uses the 2-FF synchronizer outputs directly.

Decomposition:
- Package i2c_reg_pkg holds:
  - state enum: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT
  - constants: NUM_REGS_DEF=37, AW_DEF=6, ACK=1'b0, NACK=1'b1
- One sub-module, i2c_line_sync, contains:
  - synchronizers and the optional glitch filter
  - outputs: scl_rise, scl_fall, start_det, stop_det, sda_s

Test Plan:
- Write 8'h84, ptr 8'h06, data 8'h55, 8'hAA, STOP -> reg_write pulses {addr 6, 8'h55} then {addr 7, 8'hAA}; each pulse 2 clks wide; all three bytes ACKed.
- Write ptr 8'h10, repeated START, 8'h85, read 2 bytes (ACK, NACK), register file returns 8'h3C/8'hC3 -> SDA carries 8'h3C then 8'hC3; reg_read at addr 16 and 17.
- Write ptr 8'h24 (36), data 8'h01, 8'h02 -> writes at addr 36 then addr 0 (wrap).
- Address byte 8'h20 (device 7'h10) -> no ACK, no strobes, busy high until STOP then 0.
- Ptr 8'h30 (48 >= NUM_REGS) -> NACK on pointer byte, no strobes; next transaction with ptr 8'h00 works normally.
- With I2C_GLITCH_FILTER_EN: 1-clk SDA low pulse while SCL high -> no START detected. Also assert rst during data byte -> sda_oe=0 same cycle, FSM IDLE.
